mux_tree_pipe: RTL
==================

Name: mux_tree_pipe

Overview:
- Parametrised, pipelined NUM_CH:1 multiplexer with WIDTH-bit data and a valid/ready handshake.
- Built as a log2(NUM_CH)-level tree of 2:1 stages, with a register after every level.
- Select comes from either an external port or an internal round-robin scan counter.
- Each output carries a tag giving the channel it came from. The block sits between parallel data sources and a single downstream consumer.

Parameters:
- NUM_CH, 8, number of input channels; must be a power of two, at least 2.
- WIDTH, 8, data width per channel in bits.
- SEL_W, 3, select width; must equal log2(NUM_CH). This is also the pipeline latency in cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, NUM_CH*WIDTH, packed channel data; channel k occupies din[k*WIDTH +: WIDTH].
- in_valid, input, 1, sample din/sel this cycle.
- sel, input, SEL_W, channel select, used when mode=0.
- mode, input, 1, 0 = external select, 1 = round-robin scan.
- in_ready, output, 1, block accepts input this cycle.
- dout, output, WIDTH, selected data.
- dout_ch, output, SEL_W, channel index of dout.
- out_valid, output, 1, dout/dout_ch are valid.
- out_ready, input, 1, consumer accepts output.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage data registers, valid bits, dout, dout_ch and the round-robin pointer rr_ptr are cleared to 0 immediately. out_valid=0 during reset and on the first cycle after release. A reset mid-operation discards all in-flight samples.
- Effective select: eff_sel = mode ? rr_ptr : sel, evaluated in the accept cycle.
- Accept: when in_valid && in_ready, a transfer occurs.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, combinational; it has no dependence on in_valid.
- Pipeline structure:
  - Level j (0..SEL_W-1) picks between adjacent pairs from the previous level using select bit j.
  - Each level registers its data, the remaining select bits, the full channel tag and a valid bit.
  - Level 0 is fed by din at the accept cycle.
- Stall behaviour:
  - All levels load only when adv=1. When adv=0, every level holds its contents.
  - No sample is dropped or duplicated. Bubbles are not compressed.
  - When adv=1 and in_valid=0, a bubble (valid=0) enters level 0.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+SEL_W-1, assuming no stalls. Throughput is one sample per cycle.
- dout equals din[eff_sel*WIDTH +: WIDTH] as sampled at accept; later din changes do not affect in-flight samples. dout_ch = eff_sel.
- Round-robin pointer:
  - rr_ptr increments by 1 on each accepted transfer while mode=1, and wraps NUM_CH-1 -> 0.
  - rr_ptr does not change when mode=0, when in_valid=0, or when stalled.
  - A mode change takes effect on the next accepted sample. rr_ptr keeps its value across mode changes.
- sel is ignored when mode=1. Out-of-range sel cannot occur because sel is exactly SEL_W bits.
- Output registers: dout/dout_ch hold their last value while out_valid=0. They are not cleared on bubbles.

Test Plan:
Common setup: NUM_CH=8, WIDTH=8, SEL_W=3, channel k on din = 8'h10+k.

1. Reset: assert rst_n=0 mid-stream -> out_valid, dout, dout_ch go to 0 immediately with no clock. After release, rr_ptr=0 and in_ready=1.
2. Single sample: mode=0, out_ready=1, sel=5, one in_valid pulse -> exactly one out_valid pulse, SEL_W cycles later, with dout=8'h15 and dout_ch=5.
3. Back-to-back: mode=0, sel=0..7 on consecutive cycles -> dout=8'h10..8'h17 on 8 consecutive cycles; din changes after each accept have no effect.
4. Round-robin wrap: mode=1, in_valid held for 10 cycles -> dout_ch sequence 0,1,...,7,0,1 and rr_ptr=2 afterwards. Then switch to mode=0 for 3 samples and back to mode=1 -> scan resumes at channel 2.
5. Backpressure: fill the pipe, then hold out_ready=0 for 4 cycles -> in_ready=0, dout and dout_ch stable, rr_ptr frozen. On release, outputs continue in order with no loss or duplication.
6. Bubbles: in_valid pattern 1,0,1,1,0 with sel=3 -> out_valid pattern 1,0,1,1,0 delayed by SEL_W cycles, dout=8'h13 on each valid cycle.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_CH:1 mux tree with valid/ready handshake. Each tree level is a
// row of registered 2:1 lanes, and all levels advance together.

module mux_tree_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= sel ? b : a;
  end
endmodule

module mux_tree_pipe #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        dout,
  output logic [SEL_W-1:0]        dout_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);
  logic [NUM_CH-1:0][WIDTH-1:0] din_a;
  logic                         adv;
  logic [SEL_W-1:0]             rr_ptr, eff_sel;
  logic [SEL_W:1]               vld_pipe;
  // The full channel tag travels with each sample; level j steers on tag bit j.
  logic [SEL_W:1][SEL_W-1:0]    tag_pipe;

  assign din_a     = din;
  assign out_valid = vld_pipe[SEL_W];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign eff_sel   = mode ? rr_ptr : sel;
  assign dout_ch   = tag_pipe[SEL_W];

  // Tags load only with valid samples so dout_ch holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      rr_ptr   <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) tag_pipe[1] <= eff_sel;
      for (int j = 2; j <= SEL_W; j++) begin
        vld_pipe[j] <= vld_pipe[j-1];
        if (vld_pipe[j-1]) tag_pipe[j] <= tag_pipe[j-1];
      end
      if (in_valid && mode) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  for (genvar j = 0; j < SEL_W; j++) begin : g_lvl
    localparam int N = NUM_CH >> (j + 1);
    logic [N-1:0][WIDTH-1:0] d;
    logic                    s, en;

    if (j == 0) begin : g_ctl
      assign s  = eff_sel[0];
      assign en = adv && in_valid;
    end else begin : g_ctl
      assign s  = tag_pipe[j][j];
      assign en = adv && vld_pipe[j];
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
      logic [WIDTH-1:0] a, b;
      if (j == 0) begin : g_src
        assign a = din_a[2*k];
        assign b = din_a[2*k+1];
      end else begin : g_src
        assign a = g_lvl[j-1].d[2*k];
        assign b = g_lvl[j-1].d[2*k+1];
      end
      mux_tree_lane #(.WIDTH(WIDTH)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sel   (s),
        .a     (a),
        .b     (b),
        .q     (d[k])
      );
    end
  end

  assign dout = g_lvl[SEL_W-1].d[0];
endmodule
